// File: rtl/mem_fetch_seq.sv
// -----------------------------------------------------------------------------
// mem_fetch_seq
// Burst fetch sequencer. Accepts a (base, len) request, issues len reads to a
// synchronous-read memory at consecutive word addresses (wrapping modulo
// 2^ADDR_W), buffers the returned words in a small FIFO and streams them out
// in address order with a ready/valid handshake. The final word is flagged
// with io_out_last and io_done pulses for one cycle once it has been taken.
//
// Ports
//   clock, reset        sole clock (rising edge); asynchronous active-high reset
//   io_req_*            burst request: valid/ready handshake, base address, length
//   io_mem_*            memory read port: strobe, address, data (1-cycle latency)
//   io_out_*            output stream: valid/ready handshake, data, last flag
//   io_busy             burst in progress (ISSUE, DRAIN or DONE)
//   io_done             one-cycle pulse when the burst has completed
// -----------------------------------------------------------------------------
module mem_fetch_seq #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_req_valid,
   output logic              io_req_ready,
   input  logic [ADDR_W-1:0] io_req_base,
   input  logic [5:0]        io_req_len,
   output logic              io_mem_rdEna,
   output logic [ADDR_W-1:0] io_mem_rdAddr,
   input  logic [DATA_W-1:0] io_mem_rdData,
   output logic              io_out_valid,
   input  logic              io_out_ready,
   output logic [DATA_W-1:0] io_out_data,
   output logic              io_out_last,
   output logic              io_busy,
   output logic              io_done
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int OCC_W = CNT_W + 1;
   localparam logic [OCC_W-1:0]  OCC_LIMIT = OCC_W'(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1'b1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_addr;        // next address to read
   logic [ADDR_W-1:0]   r_last_addr;   // address of most recent read, shown while idle
   logic [5:0]          r_issue_cnt;
   logic [5:0]          r_deliver_cnt;
   logic                r_inflight;
   logic                r_busy;
   logic                r_done;

   logic [DATA_W-1:0]   r_fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [CNT_W-1:0]    r_count;

   logic                w_accept;
   logic                w_rd_en;
   logic                w_push;
   logic                w_pop;
   logic                w_valid;
   logic [OCC_W-1:0]    w_occupancy;

   // A read is only issued if its word is guaranteed a FIFO slot: words already
   // buffered plus the one still coming back from memory must leave room. A pop
   // in the same cycle is ignored here, which costs nothing at full rate because
   // occupancy settles at two (one buffered, one in flight).
   assign w_occupancy = {1'b0, r_count} + {{(OCC_W-1){1'b0}}, r_inflight};
   assign w_rd_en     = (r_state == S_ISSUE) && (r_issue_cnt != 6'd0) &&
                        (w_occupancy < OCC_LIMIT);
   assign w_accept    = io_req_valid && io_req_ready;
   assign w_push      = r_inflight;
   assign w_valid     = (r_count != {CNT_W{1'b0}});
   assign w_pop       = w_valid && io_out_ready;

   // Gated by reset so the request port reads not-ready throughout reset and
   // ready immediately once it is released.
   assign io_req_ready  = (r_state == S_IDLE) && !reset;
   assign io_mem_rdEna  = w_rd_en;
   assign io_mem_rdAddr = w_rd_en ? r_addr : r_last_addr;
   assign io_out_valid  = w_valid;
   assign io_out_data   = w_valid ? r_fifo_mem[r_rd_ptr] : {DATA_W{1'b0}};
   assign io_out_last   = w_valid && (r_deliver_cnt == 6'd1);
   assign io_busy       = r_busy;
   assign io_done       = r_done;

   // Burst control FSM with its counters and the registered busy/done flags.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_addr        <= {ADDR_W{1'b0}};
         r_last_addr   <= {ADDR_W{1'b0}};
         r_issue_cnt   <= 6'd0;
         r_deliver_cnt <= 6'd0;
         r_inflight    <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         // Data for a read issued this cycle arrives next cycle.
         r_inflight <= w_rd_en;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_addr        <= io_req_base;
                  r_issue_cnt   <= io_req_len;
                  r_deliver_cnt <= io_req_len;
                  r_busy        <= 1'b1;
                  if (io_req_len == 6'd0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_ISSUE;
                     r_done  <= 1'b0;
                  end
               end
            end
            S_ISSUE: begin
               if (w_rd_en) begin
                  r_addr      <= r_addr + ADDR_ONE;
                  r_last_addr <= r_addr;
                  r_issue_cnt <= r_issue_cnt - 6'd1;
                  if (r_issue_cnt == 6'd1) begin
                     r_state <= S_DRAIN;
                  end
               end
               if (w_pop) begin
                  r_deliver_cnt <= r_deliver_cnt - 6'd1;
               end
            end
            S_DRAIN: begin
               if (w_pop) begin
                  r_deliver_cnt <= r_deliver_cnt - 6'd1;
                  if (r_deliver_cnt == 6'd1) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // FIFO pointers and occupancy; push and pop together leave occupancy unchanged.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_count  <= {CNT_W{1'b0}};
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1'b1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1'b1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1'b1);
            2'b01:   r_count <= r_count - CNT_W'(1'b1);
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO storage; contents are don't-care until pushed, so no reset is needed.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_fifo_mem[r_wr_ptr] <= io_mem_rdData;
      end
   end

endmodule
